fl_arbiter: RTL and testbench

// Shares the single free-list allocator between NUM_REQ requesters (ingress ports/queues).

---
 rtl/fl_arbiter.sv | 137 +++++++++++++
 tb/tb_fl_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fl_arbiter.sv
// Round-robin arbiter sharing one free-list allocator between NUM_REQ requesters.
// Alloc: request sampled in cycle N, gnt/fail in N+2; frees ack same cycle, blocked only before ISSUE.
package mem_pkg;
  localparam int ADDR_W = 8;
endpackage

module fl_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = mem_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        alloc_req_i,
  output logic [NUM_REQ-1:0]        alloc_gnt_o,
  output logic [NUM_REQ-1:0]        alloc_fail_o,
  output logic [ADDR_W-1:0]         alloc_block_idx_o,
  input  logic [NUM_REQ-1:0]        free_req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] free_block_idx_i,
  output logic [NUM_REQ-1:0]        free_ack_o,
  output logic                      fl_alloc_req_o,
  input  logic                      fl_alloc_gnt_i,
  input  logic [ADDR_W-1:0]         fl_alloc_block_idx_i,
  output logic                      fl_free_req_o,
  output logic [ADDR_W-1:0]         fl_free_block_idx_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0]  free_ptr_q, free_ptr_d;
  logic [PTR_W-1:0]  owner_q, owner_d;
  logic              fl_alloc_req_q, fl_alloc_req_d;
  logic              fl_free_req_q, fl_free_req_d;
  logic [ADDR_W-1:0] fl_free_idx_q, fl_free_idx_d;
  logic [PTR_W-1:0]  alloc_win;
  logic [PTR_W-1:0]  free_win;
  logic              free_slot;

  // First set bit at or after ptr, wrapping around.
  function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
    logic [PTR_W-1:0] win;
    logic             found;
    int               idx;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
    return win;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    state_d        = state_q;
    alloc_ptr_d    = alloc_ptr_q;
    free_ptr_d     = free_ptr_q;
    owner_d        = owner_q;
    fl_alloc_req_d = 1'b0;
    fl_free_req_d  = 1'b0;
    fl_free_idx_d  = fl_free_idx_q;
    free_ack_o     = '0;
    alloc_win      = rr_pick(alloc_req_i, alloc_ptr_q);
    free_win       = rr_pick(free_req_i, free_ptr_q);

    case (state_q)
      S_IDLE: begin
        if (|alloc_req_i) begin
          state_d        = S_ISSUE;
          owner_d        = alloc_win;
          fl_alloc_req_d = 1'b1;
          alloc_ptr_d    = ptr_inc(alloc_win);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A free issued now would collide with the alloc request fl sees next cycle.
    free_slot = (state_d != S_ISSUE);
    if (free_slot && (|free_req_i)) begin
      free_ack_o[free_win] = 1'b1;
      fl_free_req_d        = 1'b1;
      fl_free_idx_d        = free_block_idx_i[free_win*ADDR_W +: ADDR_W];
      free_ptr_d           = ptr_inc(free_win);
    end
  end

  always_comb begin
    alloc_gnt_o       = '0;
    alloc_fail_o      = '0;
    alloc_block_idx_o = '0;
    if (state_q == S_WAIT) begin
      alloc_gnt_o[owner_q]  = fl_alloc_gnt_i;
      alloc_fail_o[owner_q] = !fl_alloc_gnt_i;
      alloc_block_idx_o     = fl_alloc_block_idx_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      alloc_ptr_q    <= '0;
      free_ptr_q     <= '0;
      owner_q        <= '0;
      fl_alloc_req_q <= 1'b0;
      fl_free_req_q  <= 1'b0;
      fl_free_idx_q  <= '0;
    end else begin
      state_q        <= state_d;
      alloc_ptr_q    <= alloc_ptr_d;
      free_ptr_q     <= free_ptr_d;
      owner_q        <= owner_d;
      fl_alloc_req_q <= fl_alloc_req_d;
      fl_free_req_q  <= fl_free_req_d;
      fl_free_idx_q  <= fl_free_idx_d;
    end
  end

  assign fl_alloc_req_o      = fl_alloc_req_q;
  assign fl_free_req_o       = fl_free_req_q;
  assign fl_free_block_idx_o = fl_free_idx_q;

endmodule

// File: tb/tb_fl_arbiter.sv
// Bench for fl_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fl_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  alloc_req_i = '0;
  logic [N-1:0]  alloc_gnt_o, alloc_fail_o, free_ack_o;
  logic [AW-1:0] alloc_block_idx_o;
  logic [N-1:0]  free_req_i = '0;
  logic [N*AW-1:0] free_block_idx_i = '0;
  logic          fl_alloc_req_o, fl_free_req_o;
  logic          fl_alloc_gnt_i = 1'b0;
  logic [AW-1:0] fl_alloc_block_idx_i = '0;
  logic [AW-1:0] fl_free_block_idx_o;

  always #5 clk = ~clk;

  fl_arbiter #(.NUM_REQ(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_fail_o(alloc_fail_o),
    .alloc_block_idx_o(alloc_block_idx_o),
    .free_req_i(free_req_i), .free_block_idx_i(free_block_idx_i), .free_ack_o(free_ack_o),
    .fl_alloc_req_o(fl_alloc_req_o), .fl_alloc_gnt_i(fl_alloc_gnt_i),
    .fl_alloc_block_idx_i(fl_alloc_block_idx_i),
    .fl_free_req_o(fl_free_req_o), .fl_free_block_idx_o(fl_free_block_idx_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Transaction-level model: age of the one outstanding alloc (0 = none), its owner, RR pointers,
  // and the free that fl should be seeing next cycle.
  int            m_age, m_owner, m_aptr, m_fptr;
  logic          m_ffree;
  logic [AW-1:0] m_fidx;
  logic [N-1:0]  e_gnt, e_fail, e_ack;
  int            model_frees, dut_frees;
  bit            auto_on = 1'b0;

  int gnt_who[$], gnt_cyc[$], gnt_idx[$], fail_who[$], ack_who[$], ack_cyc[$], free_out[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Requester closest to ptr going upward (mod N) among those requesting.
  function automatic int rr(input logic [N-1:0] req, input int ptr);
    int best, bd, d;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr + N) % N;
      if (req[i] && d < bd) begin
        bd   = d;
        best = i;
      end
    end
    return best;
  endfunction

  task automatic clear_logs();
    gnt_who.delete(); gnt_cyc.delete(); gnt_idx.delete(); fail_who.delete();
    ack_who.delete(); ack_cyc.delete(); free_out.delete();
  endtask

  task automatic model_reset();
    m_age = 0; m_owner = 0; m_aptr = 0; m_fptr = 0; m_ffree = 1'b0; m_fidx = '0;
    e_gnt = '0; e_fail = '0; e_ack = '0;
  endtask

  task automatic step();
    int  aw, fw;
    bit  alloc_start;
    @(negedge clk);
    e_gnt  = '0;
    e_fail = '0;
    if (m_age == 2) begin
      if (fl_alloc_gnt_i) e_gnt[m_owner] = 1'b1;
      else                e_fail[m_owner] = 1'b1;
    end
    chk("alloc_gnt", alloc_gnt_o, e_gnt);
    chk("alloc_fail", alloc_fail_o, e_fail);
    chk("alloc_idx", alloc_block_idx_o, (m_age == 2) ? fl_alloc_block_idx_i : '0);
    chk("fl_alloc_req", fl_alloc_req_o, m_age == 1);
    chk("fl_free_req", fl_free_req_o, m_ffree);
    chk("fl_free_idx", fl_free_block_idx_o, m_fidx);
    chk("req_mutex", fl_alloc_req_o & fl_free_req_o, 0);

    for (int i = 0; i < N; i++) begin
      if (alloc_gnt_o[i]) begin
        gnt_who.push_back(i); gnt_cyc.push_back(cyc); gnt_idx.push_back(alloc_block_idx_o);
      end
      if (alloc_fail_o[i]) fail_who.push_back(i);
      if (free_ack_o[i]) begin ack_who.push_back(i); ack_cyc.push_back(cyc); end
    end
    if (fl_free_req_o) begin dut_frees++; free_out.push_back(fl_free_block_idx_o); end

    alloc_start = (m_age == 0) && (|alloc_req_i);
    m_age = (m_age == 1) ? 2 : 0;
    if (alloc_start) begin
      aw = rr(alloc_req_i, m_aptr);
      m_owner = aw;
      m_aptr  = (aw + 1) % N;
      m_age   = 1;
    end
    e_ack = '0;
    m_ffree = 1'b0;
    if (!alloc_start && (|free_req_i)) begin
      fw = rr(free_req_i, m_fptr);
      e_ack[fw] = 1'b1;
      m_fptr  = (fw + 1) % N;
      m_ffree = 1'b1;
      m_fidx  = free_block_idx_i[fw*AW +: AW];
      model_frees++;
    end
    chk("free_ack", free_ack_o, e_ack);

    @(posedge clk);
    #1;
    cyc++;
    if (auto_on) begin
      for (int i = 0; i < N; i++) begin
        if (e_gnt[i] || e_fail[i]) alloc_req_i[i] = 1'b0;
        else if (!alloc_req_i[i] && $urandom_range(0, 4) == 0) alloc_req_i[i] = 1'b1;
        if (e_ack[i]) free_req_i[i] = 1'b0;
        else if (!free_req_i[i] && $urandom_range(0, 2) == 0) begin
          free_req_i[i] = 1'b1;
          free_block_idx_i[i*AW +: AW] = AW'($urandom);
        end
      end
      fl_alloc_gnt_i       = ($urandom_range(0, 3) != 0);
      fl_alloc_block_idx_i = AW'($urandom);
    end
  endtask

  task automatic do_reset();
    alloc_req_i = '0;
    free_req_i  = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_fl_alloc_req", fl_alloc_req_o, 0);
    chk("rst_fl_free_req", fl_free_req_o, 0);
    chk("rst_fl_free_idx", fl_free_block_idx_o, 0);
    chk("rst_gnt", alloc_gnt_o, 0);
    chk("rst_fail", alloc_fail_o, 0);
    chk("rst_ack", free_ack_o, 0);
    chk("rst_alloc_idx", alloc_block_idx_o, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t0, nf;
    model_frees = 0;
    dut_frees   = 0;
    model_reset();

    // 1) single alloc from req0, fl grants index 5
    do_reset();
    clear_logs();
    t0 = cyc;
    alloc_req_i = 4'b0001; fl_alloc_gnt_i = 1'b1; fl_alloc_block_idx_i = 8'd5;
    repeat (3) step();
    alloc_req_i = '0;
    step();
    chk("t1_gnt_count", gnt_who.size(), 1);
    chk("t1_gnt_who", at(gnt_who, 0), 0);
    chk("t1_gnt_latency", at(gnt_cyc, 0) - t0, 2);
    chk("t1_gnt_idx", at(gnt_idx, 0), 5);

    // 2) all four requesting continuously, fl always grants
    do_reset();
    clear_logs();
    t0 = cyc;
    alloc_req_i = 4'b1111;
    repeat (15) step();
    alloc_req_i = '0;
    step();
    chk("t2_gnt_count", gnt_who.size(), 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("t2_order%0d", k), at(gnt_who, k), k % N);
      chk($sformatf("t2_cycle%0d", k), at(gnt_cyc, k) - t0, 2 + 3 * k);
    end

    // 3) free list empty: fail to owner, then FSM serves the next request
    clear_logs();
    alloc_req_i = 4'b0100; fl_alloc_gnt_i = 1'b0;
    repeat (3) step();
    alloc_req_i = '0;
    step();
    chk("t3_fail_who", at(fail_who, 0), 2);
    chk("t3_no_gnt", gnt_who.size(), 0);
    t0 = cyc;
    alloc_req_i = 4'b0001; fl_alloc_gnt_i = 1'b1;
    repeat (3) step();
    alloc_req_i = '0;
    step();
    chk("t3_next_gnt", at(gnt_who, 0), 0);
    chk("t3_next_latency", at(gnt_cyc, 0) - t0, 2);

    // 4) two frees with no allocs: consecutive acks, indices forwarded in order
    do_reset();
    clear_logs();
    free_block_idx_i = '0;
    free_block_idx_i[1*AW +: AW] = 8'd7;
    free_block_idx_i[3*AW +: AW] = 8'd9;
    free_req_i = 4'b1010;
    step();
    free_req_i[1] = 1'b0;
    step();
    free_req_i[3] = 1'b0;
    repeat (2) step();
    chk("t4_ack0", at(ack_who, 0), 1);
    chk("t4_ack1", at(ack_who, 1), 3);
    chk("t4_ack_gap", at(ack_cyc, 1) - at(ack_cyc, 0), 1);
    chk("t4_free_count", free_out.size(), 2);
    chk("t4_free_idx0", at(free_out, 0), 7);
    chk("t4_free_idx1", at(free_out, 1), 9);

    // 5) randomized concurrent alloc and free traffic
    do_reset();
    model_frees = 0;
    dut_frees   = 0;
    auto_on = 1'b1;
    repeat (800) step();
    auto_on = 1'b0;
    alloc_req_i = '0;
    free_req_i  = '0;
    repeat (4) step();
    chk("t5_free_total", dut_frees, model_frees);
    nf = model_frees;
    chk("t5_traffic_seen", nf > 50, 1);

    // 6) reset while an alloc is in ISSUE
    do_reset();
    free_block_idx_i = '0;
    free_block_idx_i[0 +: AW] = 8'h3C;
    free_req_i = 4'b0001;
    step();
    free_req_i  = '0;
    alloc_req_i = 4'b0001; fl_alloc_gnt_i = 1'b1;
    step();
    chk("t6_in_issue", fl_alloc_req_o, 1);
    chk("t6_free_idx_held", fl_free_block_idx_o, 8'h3C);
    do_reset();
    clear_logs();
    alloc_req_i = 4'b1111;
    repeat (3) step();
    alloc_req_i = '0;
    step();
    chk("t6_first_gnt", at(gnt_who, 0), 0);
    free_req_i = 4'b1111;
    step();
    free_req_i = '0;
    step();
    chk("t6_first_ack", at(ack_who, 0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
